// File: rtl/ibex_bloom_ctrl_if.sv
// EX-side request/response handshake of the bloom-filter controller.
// The master issues operations; the slave reports completion.
interface ibex_bloom_ctrl_if;
  logic        req_i;
  logic [1:0]  op_i;
  logic [31:0] key_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic        err_o;

  modport master (
    output req_i, op_i, key_i,
    input  ready_o, valid_o, result_o, err_o
  );

  modport slave (
    input  req_i, op_i, key_i,
    output ready_o, valid_o, result_o, err_o
  );
endinterface

// File: rtl/ibex_bloom_ctrl.sv
// Bloom-filter controller: INSERT/CHECK/CLEAR over a word-wide bit array.
// Optional statistics counters enabled by IBEX_BLOOM_CTRL_STATS_EN.
module ibex_bloom_ctrl #(
  parameter int unsigned NumHash = 3,
  parameter int unsigned IdxW    = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ibex_bloom_ctrl_if.slave    ex,
  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [IdxW-6:0]     ram_addr_o,
  output logic [31:0]         ram_wdata_o,
  input  logic [31:0]         ram_rdata_i,
  output logic [15:0]         stat_ins_o,
  output logic [15:0]         stat_hit_o
);

  localparam int unsigned AW = IdxW - 5;

  localparam logic [1:0] OpIns = 2'b00;
  localparam logic [1:0] OpChk = 2'b01;
  localparam logic [1:0] OpClr = 2'b10;

  typedef enum logic [2:0] {
    IDLE, RD, WAIT, WR, CLR, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   key_q, key_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          acc_q, acc_d;
  logic          res_q, res_d;
  logic          err_q, err_d;

  function automatic logic [IdxW-1:0] hash_f(
    input logic [31:0] k,
    input logic [1:0]  i
  );
    logic [5:0]        sh;
    logic [31:0]       r;
    logic [2*IdxW-1:0] e;
    sh = {1'b0, i, 3'b000};
    r  = (k << sh) | (k >> (6'd32 - sh));
    e  = (2*IdxW)'(r);
    return e[IdxW-1:0] ^ e[2*IdxW-1:IdxW]
         ^ IdxW'(32'(i) * 32'h9E37);
  endfunction

  logic [IdxW-1:0] h;
  logic [AW-1:0]   word;
  logic [4:0]      bitn;
  logic            last;

  assign h    = hash_f(key_q, idx_q);
  assign word = h[IdxW-1:5];
  assign bitn = h[4:0];
  assign last = (idx_q == 2'(NumHash - 1));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    acc_d       = acc_q;
    res_d       = res_q;
    err_d       = err_q;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ex.ready_o  = 1'b0;
    ex.valid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ex.ready_o = 1'b1;
        if (ex.req_i) begin
          op_d  = ex.op_i;
          key_d = ex.key_i;
          idx_d = '0;
          acc_d = 1'b1;
          err_d = 1'b0;
          unique case (ex.op_i)
            OpIns, OpChk: state_d = RD;
            OpClr: begin
              state_d = CLR;
              addr_d  = '0;
            end
            default: begin
              state_d = DONE;
              res_d   = 1'b0;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      RD: begin
        ram_req_o  = 1'b1;
        ram_addr_o = word;
        state_d    = WAIT;
      end
      WAIT: begin
        rdata_d = ram_rdata_i;
        if (op_q == OpChk) begin
          if (!ram_rdata_i[bitn]) begin
            state_d = DONE;
            res_d   = 1'b0;
          end else if (last) begin
            state_d = DONE;
            res_d   = 1'b1;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = RD;
          end
        end else begin
          acc_d   = acc_q & ram_rdata_i[bitn];
          state_d = WR;
        end
      end
      WR: begin
        ram_req_o   = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = word;
        ram_wdata_o = rdata_q | (32'd1 << bitn);
        if (last) begin
          state_d = DONE;
          res_d   = acc_q;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = RD;
        end
      end
      CLR: begin
        ram_req_o  = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = addr_q;
        if (addr_q == {AW{1'b1}}) begin
          state_d = DONE;
          res_d   = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DONE: begin
        ex.valid_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      key_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      acc_q   <= 1'b0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign ex.result_o = {31'b0, res_q};
  assign ex.err_o    = ex.valid_o & err_q;

`ifdef IBEX_BLOOM_CTRL_STATS_EN
  logic [15:0] ins_q;
  logic [15:0] hits_q;

  // Counters update in the completion cycle, when res_q is final.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ins_q  <= '0;
      hits_q <= '0;
    end else if (state_q == DONE) begin
      if (op_q == OpIns && ins_q != 16'hFFFF)
        ins_q <= ins_q + 16'd1;
      if (op_q == OpChk && res_q && hits_q != 16'hFFFF)
        hits_q <= hits_q + 16'd1;
      if (op_q == OpClr) begin
        ins_q  <= '0;
        hits_q <= '0;
      end
    end
  end

  assign stat_ins_o = ins_q;
  assign stat_hit_o = hits_q;
`else
  assign stat_ins_o = '0;
  assign stat_hit_o = '0;
`endif

endmodule

// File: tb/tb_ibex_bloom_ctrl.sv
// Randomized self-checking bench for ibex_bloom_ctrl (NumHash=3, IdxW=10)
// against a bit-set reference model and a behavioural RAM.
module tb_ibex_bloom_ctrl;
  localparam int NH    = 3;
  localparam int IDXW  = 10;
  localparam int WORDS = 1 << (IDXW - 5);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_req, ram_we;
  logic [IDXW-6:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [15:0] stat_ins, stat_hit;

  ibex_bloom_ctrl_if bus ();

  ibex_bloom_ctrl #(.NumHash(NH), .IdxW(IDXW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ex          (bus),
    .ram_req_o   (ram_req),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .stat_ins_o  (stat_ins),
    .stat_hit_o  (stat_hit)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [WORDS];
  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  bit model_bits [1 << IDXW];
  int exp_ins = 0;
  int exp_hit = 0;

  int          wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];

  function automatic int model_hash(input logic [31:0] k, input int i);
    logic [63:0] kk;
    longint unsigned r;
    int m;
    m  = 1 << IDXW;
    kk = {k, k} >> (32 - 8 * i);
    r  = longint'(kk[31:0]);
    return int'(((r % m) ^ ((r >> IDXW) % m)) ^ ((i * 40503) % m));
  endfunction

  task automatic model_clear();
    foreach (model_bits[b]) model_bits[b] = 1'b0;
    exp_ins = 0;
    exp_hit = 0;
  endtask

  task automatic model_insert(input logic [31:0] k, output bit hit);
    int b;
    hit = 1'b1;
    for (int i = 0; i < NH; i++) begin
      b = model_hash(k, i);
      if (!model_bits[b]) hit = 1'b0;
      model_bits[b] = 1'b1;
    end
    if (exp_ins < 65535) exp_ins++;
  endtask

  task automatic model_check(input logic [31:0] k, output bit hit, output int miss_at);
    hit = 1'b1;
    miss_at = NH;
    for (int i = 0; i < NH; i++) begin
      if (hit && !model_bits[model_hash(k, i)]) begin
        hit = 1'b0;
        miss_at = i;
      end
    end
    if (hit && exp_hit < 65535) exp_hit++;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] key, input bit hold,
                       output int lat, output logic res, output logic er,
                       output int nstrobe, output int nvalid);
    int n;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    lat = -1; res = 1'bx; er = 1'bx; nstrobe = 0; nvalid = 0;
    n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.req_i = 1'b1;
    bus.op_i  = op;
    bus.key_i = key;
    @(posedge clk);
    #1;
    if (!hold) bus.req_i = 1'b0;
    for (n = 1; n <= 200 && lat < 0; n++) begin
      @(negedge clk);
      if (ram_req) begin
        nstrobe++;
        if (ram_we) begin
          wr_addr_q.push_back(int'(ram_addr));
          wr_data_q.push_back(ram_wdata);
          wr_cyc_q.push_back(n);
        end
      end
      if (bus.valid_o) begin
        nvalid++;
        lat = n;
        res = bus.result_o[0];
        er  = bus.err_o;
        checks++;
        if (bus.result_o[31:1] !== 31'b0) begin
          errors++;
          $display("FAIL result_upper got %h want 0", bus.result_o[31:1]);
        end
      end
    end
    bus.req_i = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%0d key=%h no valid_o within 200 cycles", op, key);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_i = 1'b0;
    bus.op_i  = 2'b00;
    bus.key_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ready_o, bus.valid_o, bus.err_o, ram_req, ram_we} !== 5'b10000 ||
        bus.result_o !== 32'd0 || stat_ins !== 16'd0 || stat_hit !== 16'd0) begin
      errors++;
      $display("FAIL reset rdy=%b vld=%b err=%b req=%b we=%b res=%h want 1,0,0,0,0,0",
               bus.ready_o, bus.valid_o, bus.err_o, ram_req, ram_we, bus.result_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clear();
    int lat, ns, nv;
    logic res, er;
    bit ok;
    do_op(2'b10, 32'h0, 1'b0, lat, res, er, ns, nv);
    model_clear();
    checks++;
    if (lat !== WORDS + 1 || res !== 1'b0 || er !== 1'b0) begin
      errors++;
      $display("FAIL clear_done lat=%0d res=%b err=%b want %0d,0,0", lat, res, er, WORDS + 1);
    end
    ok = (wr_addr_q.size() == WORDS) && (ns == WORDS);
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] != i || wr_data_q[i] !== 32'd0 || wr_cyc_q[i] != i + 1) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL clear_writes got %0d writes/%0d strobes want %0d zero writes addr 0..%0d",
               wr_addr_q.size(), ns, WORDS, WORDS - 1);
    end
  endtask

  task automatic test_vectors();
    int lat, ns, nv, mj;
    logic res, er;
    bit mh;
    do_op(2'b01, 32'h1, 1'b0, lat, res, er, ns, nv);
    model_check(32'h1, mh, mj);
    checks++;
    if (lat !== 3 || res !== 1'b0 || mh !== 1'b0 || ns != 1) begin
      errors++;
      $display("FAIL check_key1 lat=%0d res=%b reads=%0d want 3,0,1", lat, res, ns);
    end
    do_op(2'b00, 32'h0, 1'b0, lat, res, er, ns, nv);
    model_insert(32'h0, mh);
    checks++;
    if (lat !== 10 || res !== 1'b0) begin
      errors++;
      $display("FAIL insert_key0 lat=%0d res=%b want 10,0", lat, res);
    end
    checks++;
    if (wr_addr_q.size() != 3 || ns != 6 ||
        wr_addr_q[0] != 0  || wr_data_q[0] !== 32'h00000001 ||
        wr_addr_q[1] != 17 || wr_data_q[1] !== 32'h00800000 ||
        wr_addr_q[2] != 3  || wr_data_q[2] !== 32'h00004000) begin
      errors++;
      $display("FAIL insert_key0_writes n=%0d strobes=%0d want w0=1 w17=00800000 w3=00004000",
               wr_addr_q.size(), ns);
    end
    do_op(2'b01, 32'h0, 1'b0, lat, res, er, ns, nv);
    model_check(32'h0, mh, mj);
    checks++;
    if (lat !== 7 || res !== 1'b1 || ns != 3) begin
      errors++;
      $display("FAIL check_key0 lat=%0d res=%b reads=%0d want 7,1,3", lat, res, ns);
    end
    checks++;
    if (bus.result_o !== 32'd1) begin
      errors++;
      $display("FAIL result_hold got %h want 00000001", bus.result_o);
    end
  endtask

  task automatic test_reserved();
    int lat, ns, nv;
    logic res, er;
    do_op(2'b11, $urandom, 1'b0, lat, res, er, ns, nv);
    checks++;
    if (lat !== 1 || er !== 1'b1 || res !== 1'b0 || ns != 0) begin
      errors++;
      $display("FAIL reserved lat=%0d err=%b res=%b strobes=%0d want 1,1,0,0", lat, er, res, ns);
    end
  endtask

  task automatic test_back_to_back();
    int lat, ns, nv;
    logic res, er;
    bit mh;
    logic [31:0] k;
    k = $urandom;
    do_op(2'b00, k, 1'b1, lat, res, er, ns, nv);
    model_insert(k, mh);
    checks++;
    if (lat !== 3 * NH + 1 || nv != 1 || res !== mh) begin
      errors++;
      $display("FAIL busy_hold lat=%0d valids=%0d res=%b want %0d,1,%b", lat, nv, res, 3 * NH + 1, mh);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || ram_req !== 1'b0) begin
      errors++;
      $display("FAIL busy_queued rdy=%b req=%b want 1,0", bus.ready_o, ram_req);
    end
  endtask

  task automatic test_random();
    int lat, ns, nv, mj, want_lat;
    logic res, er;
    bit mh;
    logic [31:0] pool [8];
    logic [31:0] k;
    logic [1:0] op;
    foreach (pool[p]) pool[p] = $urandom;
    for (int t = 0; t < 60; t++) begin
      k  = ($urandom_range(0, 2) != 0) ? pool[$urandom_range(0, 7)] : $urandom;
      op = $urandom_range(0, 1) != 0 ? 2'b01 : 2'b00;
      do_op(op, k, 1'b0, lat, res, er, ns, nv);
      if (op == 2'b00) begin
        model_insert(k, mh);
        want_lat = 3 * NH + 1;
      end else begin
        model_check(k, mh, mj);
        want_lat = mh ? 2 * NH + 1 : 2 * mj + 3;
      end
      checks++;
      if (res !== mh || lat !== want_lat || er !== 1'b0) begin
        errors++;
        $display("FAIL random op=%0d key=%h res=%b lat=%0d err=%b want %b,%0d,0",
                 op, k, res, lat, er, mh, want_lat);
      end
    end
  endtask

  task automatic test_stats();
    int lat, ns, nv;
    logic res, er;
    int wi, wh;
`ifdef IBEX_BLOOM_CTRL_STATS_EN
    wi = exp_ins;
    wh = exp_hit;
`else
    wi = 0;
    wh = 0;
`endif
    checks++;
    if (stat_ins !== 16'(wi) || stat_hit !== 16'(wh)) begin
      errors++;
      $display("FAIL stats ins=%0d hit=%0d want %0d,%0d", stat_ins, stat_hit, wi, wh);
    end
    do_op(2'b10, 32'h0, 1'b0, lat, res, er, ns, nv);
    model_clear();
    @(negedge clk);
    checks++;
    if (stat_ins !== 16'd0 || stat_hit !== 16'd0) begin
      errors++;
      $display("FAIL stats_clear ins=%0d hit=%0d want 0,0", stat_ins, stat_hit);
    end
  endtask

  task automatic test_reset_mid();
    int lat, ns, nv;
    logic res, er;
    bit mh;
    @(negedge clk);
    bus.req_i = 1'b1;
    bus.op_i  = 2'b00;
    bus.key_i = $urandom;
    @(posedge clk);
    #1 bus.req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_req !== 1'b1 || ram_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_wr_phase req=%b we=%b want 1,1", ram_req, ram_we);
    end
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || ram_req !== 1'b0 ||
        bus.result_o !== 32'd0 || stat_ins !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid rdy=%b vld=%b req=%b res=%h want 1,0,0,0",
               bus.ready_o, bus.valid_o, ram_req, bus.result_o);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b0 || ram_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after vld=%b req=%b want 0,0", bus.valid_o, ram_req);
      end
    end
    do_op(2'b10, 32'h0, 1'b0, lat, res, er, ns, nv);
    model_clear();
    do_op(2'b00, 32'h0, 1'b0, lat, res, er, ns, nv);
    model_insert(32'h0, mh);
    checks++;
    if (res !== mh || lat !== 3 * NH + 1) begin
      errors++;
      $display("FAIL post_reset_insert res=%b lat=%0d want %b,%0d", res, lat, mh, 3 * NH + 1);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_vectors();
    test_reserved();
    test_back_to_back();
    test_random();
    test_stats();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_bloom_ctrl.md
IBEX_BLOOM_CTRL -- requirements
Module: ibex_bloom_ctrl

Interface
REQ-001 Parameter NumHash, default 3: hash functions per key; legal range 1..4.
REQ-002 Parameter IdxW, default 10: bloom array bit-index width; legal range 6..16; Words = 2^(IdxW-5) 32-bit words.
REQ-003 clk_i  in  1  sole clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 req_i  in  1  operation request from EX; accepted when req_i && ready_o.
REQ-006 op_i  in  2  00 INSERT, 01 CHECK, 10 CLEAR, 11 reserved.
REQ-007 key_i  in  32  key (rs1 value); sampled on acceptance.
REQ-008 ready_o  out  1  controller idle, can accept.
REQ-009 valid_o  out  1  one-cycle completion pulse.
REQ-010 result_o  out  32  {31'b0, hit}; held stable from valid_o until next acceptance.
REQ-011 err_o  out  1  qualified by valid_o; reserved op.
REQ-012 ram_req_o / ram_we_o  out  1 / 1  array RAM access strobe / write enable.
REQ-013 ram_addr_o  out  IdxW-5  word address.
REQ-014 ram_wdata_o  out  32  write data.
REQ-015 ram_rdata_i  in  32  read data, valid exactly one cycle after a read strobe.
REQ-016 stat_ins_o / stat_hit_o  out  16 / 16  statistics counters (see Configuration).

Function
REQ-017 Hash i (0..NumHash-1): r = rotl(key, 8*i); h_i = r[IdxW-1:0] ^ r[2*IdxW-1:IdxW] ^ (i*16'h9E37)[IdxW-1:0]; bits of r above 31 read as 0; word = h_i[IdxW-1:5], bit = h_i[4:0].
REQ-018 FSM states IDLE, RD, WAIT, WR, CLR, DONE; ready_o=1 only in IDLE.
REQ-019 IDLE: on acceptance latch op, key, i=0; INSERT/CHECK -> RD; CLEAR -> CLR, addr=0; reserved -> DONE with result 0, err_o=1.
REQ-020 RD: ram_req_o=1, ram_we_o=0, ram_addr_o=word(h_i); -> WAIT.
REQ-021 WAIT: capture ram_rdata_i; CHECK: bit clear -> DONE hit=0; bit set and i=NumHash-1 -> DONE hit=1; else i++ -> RD. INSERT: -> WR.
REQ-022 WR: ram_req_o=1, ram_we_o=1, same address, wdata = captured | (1<<bit); i=NumHash-1 -> DONE, else i++ -> RD.
REQ-023 INSERT hit = 1 iff every probed bit was already set before its write.
REQ-024 CLR: ram_req_o=1, ram_we_o=1, wdata=0, one word per cycle, addr 0..Words-1; after last word -> DONE, hit=0.
REQ-025 DONE: valid_o=1 for exactly one cycle; -> IDLE.
REQ-026 Latency from acceptance cycle T: CHECK all-set valid at T+2*NumHash+1; CHECK early miss at probe j valid at T+2*j+3; INSERT T+3*NumHash+1; CLEAR T+Words+1; reserved T+1.
REQ-027 req_i while ready_o=0 is ignored and not queued; back-to-back acceptance possible the cycle after valid_o.
REQ-028 Outside RD, WR, CLR: ram_req_o=0, ram_we_o=0; ram_addr_o/ram_wdata_o are don't-care.
REQ-029 Duplicate hash words within one INSERT are handled because each write completes before the next read.

Reset
REQ-030 rst_ni low at a clock edge: state IDLE, i=0, ready_o=1, valid_o=0, err_o=0, result_o=0, ram_req_o=0, ram_we_o=0, counters 0.
REQ-031 Reset mid-operation aborts without completion pulse; RAM contents are not cleared; no RAM strobe in the cycle after reset.

Configuration
REQ-032 Macro IBEX_BLOOM_CTRL_STATS_EN defined: stat_ins_o increments on each INSERT completion; stat_hit_o increments on each CHECK completion with hit=1; both saturate at 16'hFFFF; both zeroed on CLEAR completion.
REQ-033 Macro undefined: no counter flops; stat_ins_o and stat_hit_o tied to 0.

Verification (NumHash=3, IdxW=10)
REQ-034 CLEAR accepted at T -> 32 zero writes, addr 0..31 on T+1..T+32, valid_o at T+33, result 0.
REQ-035 After clear, INSERT key 0 -> writes word0=0x00000001, word17=0x00800000, word3=0x00004000; valid_o at T+10, result 0.
REQ-036 Then CHECK key 0 -> three reads, valid_o at T+7, result 1; CHECK key 0x00000001 after clear -> miss at first probe, valid_o at T+3, result 0.
REQ-037 op_i=11 -> valid_o at T+1, err_o=1, result 0, no RAM strobe; req_i held during busy INSERT -> single acceptance only.
REQ-038 rst_ni low during WR of INSERT -> next cycle ready_o=1, valid_o=0, ram_req_o=0; with STATS_EN, 65537 INSERTs -> stat_ins_o=16'hFFFF.
